// File: rtl/wb_write_queue_pkg.sv
// Shared widths and entry layout for the writeback queue.
package wb_write_queue_pkg;

    localparam int WBQ_AW = 4;
    localparam int WBQ_DW = 16;

    typedef struct packed {
        logic [WBQ_AW-1:0] reg1;
        logic [WBQ_DW-1:0] data1;
        logic              dual;
        logic [WBQ_AW-1:0] reg2;
        logic [WBQ_DW-1:0] data2;
    } wbq_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// Forwarding lookup over queued entries; entry 0 is the youngest.
module wbq_fwd_match
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input  logic [AW-1:0]             q_reg,
    input  logic [DEPTH-1:0]          ent_vld,
    input  logic [DEPTH-1:0][AW-1:0]  ent_reg1,
    input  logic [DEPTH-1:0][DW-1:0]  ent_data1,
    input  logic [DEPTH-1:0]          ent_dual,
    input  logic [DEPTH-1:0][AW-1:0]  ent_reg2,
    input  logic [DEPTH-1:0][DW-1:0]  ent_data2,
    output logic                      q_hit,
    output logic [DW-1:0]             q_data
);

    // Walk oldest to youngest so later matches override; slot2 checked last wins within an entry.
    always_comb begin
        q_hit  = 1'b0;
        q_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (ent_vld[k] && ent_reg1[k] == q_reg) begin
                q_hit  = 1'b1;
                q_data = ent_data1[k];
            end
            if (ent_vld[k] && ent_dual[k] && ent_reg2[k] == q_reg) begin
                q_hit  = 1'b1;
                q_data = ent_data2[k];
            end
        end
    end

endmodule

// File: rtl/wb_write_queue.sv
// Writeback FIFO between execute results and the register file, with forwarding of pending values.
module wb_write_queue
    import wb_write_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = WBQ_AW,
    parameter int DW    = WBQ_DW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_reg1,
    input  logic [DW-1:0]              in_data1,
    input  logic                       in_dual,
    input  logic [AW-1:0]              in_reg2,
    input  logic [DW-1:0]              in_data2,
    input  logic                       hold,
    output logic                       RegWrite,
    output logic                       WriteOP2,
    output logic [AW-1:0]              WriteReg1,
    output logic [AW-1:0]              WriteReg2,
    output logic [DW-1:0]              WriteData1,
    output logic [DW-1:0]              WriteData2,
    input  logic [AW-1:0]              q_reg1,
    input  logic [AW-1:0]              q_reg2,
    output logic                       q_hit1,
    output logic                       q_hit2,
    output logic [DW-1:0]              q_data1,
    output logic [DW-1:0]              q_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    // Same field order as wbq_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [AW-1:0] reg1;
        logic [DW-1:0] data1;
        logic          dual;
        logic [AW-1:0] reg2;
        logic [DW-1:0] data2;
    } entry_t;

    entry_t [DEPTH-1:0] mem_q, mem_d;
    logic [DEPTH-1:0]   vld_q, vld_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]      count_q, count_d;
    logic               push, pop, empty;
    entry_t             head;

    assign empty    = (count_q == '0);
    assign in_ready = (count_q < CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign head     = empty ? '0 : mem_q[rd_ptr_q];

    assign RegWrite   = !empty && !hold;
    assign WriteOP2   = RegWrite && head.dual;
    assign WriteReg1  = head.reg1;
    assign WriteData1 = head.data1;
    assign WriteReg2  = head.reg2;
    assign WriteData2 = head.data2;
    assign pop        = RegWrite;
    assign count      = count_q;

    always_comb begin
        mem_d    = mem_q;
        vld_d    = vld_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (pop) begin
            vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d        = rd_ptr_q + 1'b1;
        end
        // A full queue never pushes, so push and pop never target the same slot.
        if (push) begin
            mem_d[wr_ptr_q] = '{reg1: in_reg1, data1: in_data1, dual: in_dual,
                                reg2: in_reg2, data2: in_data2};
            vld_d[wr_ptr_q] = 1'b1;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            vld_q    <= vld_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Reorder storage by age for the matchers: index 0 is the most recent push.
    logic [DEPTH-1:0]         age_vld, age_dual;
    logic [DEPTH-1:0][AW-1:0] age_reg1, age_reg2;
    logic [DEPTH-1:0][DW-1:0] age_data1, age_data2;

    for (genvar k = 0; k < DEPTH; k++) begin : g_age
        logic [PW-1:0] idx;
        assign idx          = wr_ptr_q - PW'(k + 1);
        assign age_vld[k]   = vld_q[idx];
        assign age_reg1[k]  = mem_q[idx].reg1;
        assign age_data1[k] = mem_q[idx].data1;
        assign age_dual[k]  = mem_q[idx].dual;
        assign age_reg2[k]  = mem_q[idx].reg2;
        assign age_data2[k] = mem_q[idx].data2;
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd1 (
        .q_reg    (q_reg1),
        .ent_vld  (age_vld),
        .ent_reg1 (age_reg1),
        .ent_data1(age_data1),
        .ent_dual (age_dual),
        .ent_reg2 (age_reg2),
        .ent_data2(age_data2),
        .q_hit    (q_hit1),
        .q_data   (q_data1)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd2 (
        .q_reg    (q_reg2),
        .ent_vld  (age_vld),
        .ent_reg1 (age_reg1),
        .ent_data1(age_data1),
        .ent_dual (age_dual),
        .ent_reg2 (age_reg2),
        .ent_data2(age_data2),
        .q_hit    (q_hit2),
        .q_data   (q_data2)
    );

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and random checks of wb_write_queue against a queue-based reference model.
module tb_wb_write_queue;
    import wb_write_queue_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = WBQ_AW;
    localparam int DW    = WBQ_DW;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0, in_dual = 1'b0, hold = 1'b0;
    logic [AW-1:0] in_reg1 = '0, in_reg2 = '0, q_reg1 = '0, q_reg2 = '0;
    logic [DW-1:0] in_data1 = '0, in_data2 = '0;
    logic          in_ready, RegWrite, WriteOP2, q_hit1, q_hit2;
    logic [AW-1:0] WriteReg1, WriteReg2;
    logic [DW-1:0] WriteData1, WriteData2, q_data1, q_data2;
    logic [CW-1:0] count;

    int total = 0;
    int bad   = 0;
    wbq_entry_t mq[$];

    always #5 clk = ~clk;

    wb_write_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_reg1(in_reg1), .in_data1(in_data1), .in_dual(in_dual),
        .in_reg2(in_reg2), .in_data2(in_data2), .hold(hold),
        .RegWrite(RegWrite), .WriteOP2(WriteOP2),
        .WriteReg1(WriteReg1), .WriteReg2(WriteReg2),
        .WriteData1(WriteData1), .WriteData2(WriteData2),
        .q_reg1(q_reg1), .q_reg2(q_reg2),
        .q_hit1(q_hit1), .q_hit2(q_hit2),
        .q_data1(q_data1), .q_data2(q_data2), .count(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Youngest pending write to the address wins; second slot beats first within an entry.
    function automatic void model_fwd(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
        hit = 1'b0;
        d   = '0;
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].dual && mq[i].reg2 == a) begin hit = 1'b1; d = mq[i].data2; return; end
            if (mq[i].reg1 == a) begin hit = 1'b1; d = mq[i].data1; return; end
        end
    endfunction

    // Check all outputs for the current inputs, then advance one edge in DUT and model.
    task automatic step();
        logic          erw, epush, h;
        logic [DW-1:0] d;
        wbq_entry_t    hd;
        #1;
        erw   = (mq.size() != 0) && !hold;
        epush = in_valid && (mq.size() < DEPTH);
        hd    = (mq.size() != 0) ? mq[0] : '0;
        chk("in_ready", in_ready, mq.size() < DEPTH);
        chk("RegWrite", RegWrite, erw);
        chk("WriteOP2", WriteOP2, erw && hd.dual);
        chk("WriteReg1", WriteReg1, hd.reg1);
        chk("WriteData1", WriteData1, hd.data1);
        if (mq.size() == 0 || hd.dual) begin
            chk("WriteReg2", WriteReg2, hd.reg2);
            chk("WriteData2", WriteData2, hd.data2);
        end
        chk("count", count, mq.size());
        model_fwd(q_reg1, h, d);
        chk("q_hit1", q_hit1, h);
        chk("q_data1", q_data1, d);
        model_fwd(q_reg2, h, d);
        chk("q_hit2", q_hit2, h);
        chk("q_data2", q_data2, d);
        @(posedge clk);
        if (erw) void'(mq.pop_front());
        if (epush) mq.push_back('{in_reg1, in_data1, in_dual, in_reg2, in_data2});
        #1;
    endtask

    task automatic set_in(input logic v, input logic [AW-1:0] r1, input logic [DW-1:0] d1,
                          input logic du, input logic [AW-1:0] r2, input logic [DW-1:0] d2);
        in_valid = v; in_reg1 = r1; in_data1 = d1; in_dual = du; in_reg2 = r2; in_data2 = d2;
    endtask

    initial begin
        // Reset state while rst is held low.
        #3;
        chk("rst_RegWrite", RegWrite, 1'b0);
        chk("rst_WriteOP2", WriteOP2, 1'b0);
        chk("rst_WriteData1", WriteData1, '0);
        chk("rst_count", count, '0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_q_hit1", q_hit1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Single push, written the following cycle.
        set_in(1'b1, 4'd3, 16'h1234, 1'b0, 4'd0, 16'h0);
        step();
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        chk("single_RegWrite", RegWrite, 1'b1);
        chk("single_WriteReg1", WriteReg1, 4'd3);
        chk("single_WriteData1", WriteData1, 16'h1234);
        step();
        step();

        // Fill under hold: fifth push refused.
        hold = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_in(1'b1, AW'(i + 8), DW'(16'hA000 + i), 1'b0, 4'd0, 16'h0);
            step();
        end
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("full_count", count, 4);
        chk("full_in_ready", in_ready, 1'b0);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) step();

        // Youngest duplicate wins forwarding.
        hold = 1'b1;
        q_reg1 = 4'd5;
        set_in(1'b1, 4'd5, 16'h0011, 1'b0, 4'd0, 16'h0);
        step();
        set_in(1'b1, 4'd5, 16'hBEEF, 1'b0, 4'd0, 16'h0);
        step();
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("dup_q_hit1", q_hit1, 1'b1);
        chk("dup_q_data1", q_data1, 16'hBEEF);
        hold = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Dual entry, then dual entry with identical destinations.
        q_reg2 = 4'd15;
        set_in(1'b1, 4'd2, 16'hAAAA, 1'b1, 4'd15, 16'h5555);
        step();
        set_in(1'b1, 4'd7, 16'h1111, 1'b1, 4'd7, 16'h2222);
        q_reg1 = 4'd7;
        #1;
        chk("dual_WriteOP2", WriteOP2, 1'b1);
        chk("dual_WriteReg2", WriteReg2, 4'd15);
        chk("dual_WriteData2", WriteData2, 16'h5555);
        chk("dual_q_data2", q_data2, 16'h5555);
        step();
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        #1;
        chk("same_q_data1", q_data1, 16'h2222);
        for (int i = 0; i < 2; i++) step();

        // Mid-cycle reset discards queued entries.
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, AW'(i + 1), DW'(16'h0C00 + i), 1'b0, 4'd0, 16'h0);
            step();
        end
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        hold = 1'b0;
        q_reg1 = 4'd1;
        #1;
        rst = 1'b0;
        #1;
        chk("mrst_RegWrite", RegWrite, 1'b0);
        chk("mrst_count", count, '0);
        chk("mrst_q_hit1", q_hit1, 1'b0);
        mq.delete();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) step();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom),
                   1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom));
            hold   = ($urandom_range(0, 3) == 0);
            q_reg1 = AW'($urandom);
            q_reg2 = AW'($urandom);
            step();
        end
        set_in(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0);
        hold = 1'b0;
        for (int i = 0; i < DEPTH + 1; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
